regfile_2r1w_sb: RTL and testbench



---
 rtl/regfile_2r1w_sb.sv | 127 ++++++++++++
 tb/tb_regfile_2r1w_sb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_sb.sv
// 32-entry general-purpose register file with two read ports and one write port.
// Stored values are read combinationally through a 32:1 select on each port.
// With BYPASS set, a write arriving in the current cycle is forwarded straight
// to a read port that selects the same register. A per-register busy
// scoreboard tracks long-latency results (mult/div) still awaiting writeback,
// and the stall output tells the pipeline to hold a dependent read.
// Register 0 is hardwired to zero, can never be written and is never busy.
module regfile_2r1w_sb #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB,
  input  logic             ctrl_markBusy,
  input  logic [4:0]       ctrl_busyReg,
  output logic             busy_A,
  output logic             busy_B,
  output logic             stall
);

  localparam int  NREGS = 32;
  localparam bit  BYP   = (BYPASS != 0);

  // Storage. Entry 0 is held at zero by reset and never written, so reads
  // of index 0 come out as zero even before the explicit read-side guard.
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Decoded write and mark strobes; index 0 is filtered out here once.
  logic wr_valid;
  logic mk_valid;

  // Per-port bypass hits and raw select outputs.
  logic             byp_hit_a;
  logic             byp_hit_b;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Qualify the strobes against the hardwired-zero register.
  always_comb begin
    wr_valid = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
    mk_valid = ctrl_markBusy    && (ctrl_busyReg  != 5'd0);
  end

  // Register array: asynchronous clear, one write per rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Scoreboard next state: writeback clears, issue sets. The set is applied
  // last so that when a new long-latency op targets the register being
  // written back on the same edge, the newer op's pending state survives.
  always_comb begin
    busy_d = busy_q;
    if (wr_valid) begin
      busy_d[ctrl_writeReg] = 1'b0;
    end
    if (mk_valid) begin
      busy_d[ctrl_busyReg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard state: asynchronous clear, otherwise follows busy_d.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // 32:1 read selects straight off the stored array.
  always_comb begin
    sel_a = regs_q[ctrl_readRegA];
    sel_b = regs_q[ctrl_readRegB];
  end

  // Same-cycle forwarding detect. Gated by reset_n so that a write strobe
  // asserted while reset is held cannot leak data onto the read ports.
  always_comb begin
    byp_hit_a = BYP && reset_n && wr_valid && (ctrl_writeReg == ctrl_readRegA);
    byp_hit_b = BYP && reset_n && wr_valid && (ctrl_writeReg == ctrl_readRegB);
  end

  // Read data: index 0 is always zero, then forwarded data, then storage.
  always_comb begin
    if (ctrl_readRegA == 5'd0) begin
      data_readRegA = '0;
    end else if (byp_hit_a) begin
      data_readRegA = data_writeReg;
    end else begin
      data_readRegA = sel_a;
    end

    if (ctrl_readRegB == 5'd0) begin
      data_readRegB = '0;
    end else if (byp_hit_b) begin
      data_readRegB = data_writeReg;
    end else begin
      data_readRegB = sel_b;
    end
  end

  // Hazard flags: a pending register is no longer a hazard when its
  // writeback is being forwarded this very cycle.
  always_comb begin
    busy_A = busy_q[ctrl_readRegA] && !byp_hit_a;
    busy_B = busy_q[ctrl_readRegB] && !byp_hit_b;
    stall  = busy_A || busy_B;
  end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb. Two instances share every input, one built with
// forwarding enabled and one without, and both are compared every cycle to a
// behavioural model held in plain arrays.
module tb_regfile_2r1w_sb;

  // ---------------- clock / reset ----------------
  logic        clock;
  logic        reset_n;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        mk;
  logic [4:0]  br;

  logic [31:0] rda1, rdb1, rda0, rdb0;
  logic        ba1, bb1, st1, ba0, bb0, st0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  regfile_2r1w_sb #(.WIDTH(32), .BYPASS(1)) dut_byp (
    .clock(clock), .reset_n(reset_n),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rda1), .data_readRegB(rdb1),
    .ctrl_markBusy(mk), .ctrl_busyReg(br),
    .busy_A(ba1), .busy_B(bb1), .stall(st1)
  );

  regfile_2r1w_sb #(.WIDTH(32), .BYPASS(0)) dut_nobyp (
    .clock(clock), .reset_n(reset_n),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rda0), .data_readRegB(rdb0),
    .ctrl_markBusy(mk), .ctrl_busyReg(br),
    .busy_A(ba0), .busy_B(bb0), .stall(st0)
  );

  // ---------------- reference model ----------------
  logic [31:0] mdl_reg  [32];
  bit          mdl_busy [32];
  int          n_checks;
  int          n_bad;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mdl_reg[i]  = '0;
      mdl_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_data(bit byp, logic [4:0] idx);
    if (!reset_n || idx == 0) return '0;
    if (byp && we && wr == idx) return wd;
    return mdl_reg[idx];
  endfunction

  function automatic bit exp_busy(bit byp, logic [4:0] idx);
    if (!reset_n) return 1'b0;
    return mdl_busy[idx] && !(byp && we && wr == idx);
  endfunction

  // Apply one rising edge to the model with the inputs currently driven.
  task automatic model_edge();
    bit nb [32];
    if (!reset_n) begin
      model_clear();
      return;
    end
    for (int i = 1; i < 32; i++) begin
      if (mk && br == i)      nb[i] = 1'b1;
      else if (we && wr == i) nb[i] = 1'b0;
      else                    nb[i] = mdl_busy[i];
    end
    nb[0] = 1'b0;
    if (we && wr != 0) mdl_reg[wr] = wd;
    for (int i = 0; i < 32; i++) mdl_busy[i] = nb[i];
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(bit we_v, logic [4:0] wr_v, logic [31:0] wd_v,
                       logic [4:0] ra_v, logic [4:0] rb_v,
                       bit mk_v, logic [4:0] br_v);
    we = we_v; wr = wr_v; wd = wd_v; ra = ra_v; rb = rb_v; mk = mk_v; br = br_v;
  endtask

  task automatic drive_idle(logic [4:0] ra_v, logic [4:0] rb_v);
    drive(1'b0, 5'd0, 32'd0, ra_v, rb_v, 1'b0, 5'd0);
  endtask

  // Compare all outputs of both instances against the model, right now.
  task automatic check_now(string name);
    logic [31:0] ea, eb, ga, gb;
    bit xa, xb, xs;
    logic ya, yb, ys;
    bit byp;
    for (int k = 0; k < 2; k++) begin
      byp = (k == 0);
      ea = exp_data(byp, ra);
      eb = exp_data(byp, rb);
      xa = exp_busy(byp, ra);
      xb = exp_busy(byp, rb);
      xs = xa | xb;
      ga = byp ? rda1 : rda0;
      gb = byp ? rdb1 : rdb0;
      ya = byp ? ba1 : ba0;
      yb = byp ? bb1 : bb0;
      ys = byp ? st1 : st0;
      n_checks++;
      if (ga !== ea) begin
        n_bad++;
        $display("FAIL %s byp=%0d data_A(r%0d): got %h want %h", name, byp, ra, ga, ea);
      end
      n_checks++;
      if (gb !== eb) begin
        n_bad++;
        $display("FAIL %s byp=%0d data_B(r%0d): got %h want %h", name, byp, rb, gb, eb);
      end
      n_checks++;
      if (ya !== xa) begin
        n_bad++;
        $display("FAIL %s byp=%0d busy_A(r%0d): got %b want %b", name, byp, ra, ya, xa);
      end
      n_checks++;
      if (yb !== xb) begin
        n_bad++;
        $display("FAIL %s byp=%0d busy_B(r%0d): got %b want %b", name, byp, rb, yb, xb);
      end
      n_checks++;
      if (ys !== xs) begin
        n_bad++;
        $display("FAIL %s byp=%0d stall: got %b want %b", name, byp, ys, xs);
      end
    end
  endtask

  // One cycle: check mid-cycle, take the edge, land just after it.
  task automatic step(string name);
    @(negedge clock);
    check_now(name);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    model_clear();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'($urandom_range(0, 31)), $urandom, 5'(i), 5'(31 - i),
            1'b1, 5'($urandom_range(0, 31)));
      step("reset_read");
    end
    reset_n = 1'b1;
    drive_idle(5'd1, 5'd31);
    step("reset_release");
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0, 5'd0);
    step("write_r5");
    drive_idle(5'd5, 5'd0);
    step("read_r5");
  endtask

  task automatic test_write_r0();
    drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0);
    step("write_r0");
    drive_idle(5'd0, 5'd5);
    step("read_r0");
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b0, 5'd0);
    step("preload_r7");
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5, 1'b0, 5'd0);
    step("bypass_r7");
    drive_idle(5'd7, 5'd7);
    step("after_bypass_r7");
    // Forwarding on port B only, and a write to r0 must not forward.
    drive(1'b1, 5'd12, 32'h0BADF00D, 5'd7, 5'd12, 1'b0, 5'd0);
    step("bypass_B_only");
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0);
    step("bypass_r0");
  endtask

  task automatic test_scoreboard();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd9);
    step("mark_r9");
    for (int i = 0; i < 4; i++) begin
      drive_idle(5'd1, 5'd9);
      step("hold_busy_r9");
    end
    drive(1'b1, 5'd9, 32'h00000042, 5'd1, 5'd9, 1'b0, 5'd0);
    step("writeback_r9");
    drive_idle(5'd9, 5'd9);
    step("after_writeback_r9");
    // Marking r0 must never set anything.
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0);
    step("mark_r0");
    drive_idle(5'd0, 5'd0);
    step("read_busy_r0");
  endtask

  task automatic test_set_clear_same();
    drive(1'b1, 5'd3, 32'h00000001, 5'd0, 5'd0, 1'b1, 5'd3);
    step("set_clear_r3");
    drive_idle(5'd3, 5'd3);
    step("after_set_clear_r3");
    // Set and clear on different registers in one edge.
    drive(1'b1, 5'd3, 32'h00000002, 5'd0, 5'd0, 1'b1, 5'd4);
    step("set_r4_clear_r3");
    drive_idle(5'd3, 5'd4);
    step("after_set_r4_clear_r3");
  endtask

  task automatic test_random();
    logic [4:0] w;
    for (int i = 0; i < 400; i++) begin
      w = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 1) == 1, w, $urandom,
            ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31)),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)));
      step("random");
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 5'd9);
    step("setup_mid_reset");
    drive_idle(5'd5, 5'd9);
    @(negedge clock);
    check_now("before_mid_reset");
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_now("mid_reset_immediate");
    @(posedge clock);
    model_edge();
    #1;
    reset_n = 1'b1;
    drive_idle(5'd5, 5'd9);
    step("after_mid_reset");
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    n_checks = 0;
    n_bad    = 0;
    reset_n  = 1'b0;
    drive_idle(5'd0, 5'd0);
    test_reset();
    test_write_read();
    test_write_r0();
    test_bypass();
    test_scoreboard();
    test_set_clear_same();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
